// File: rtl/handshake_constant_rr_arbiter_if.sv
// Handshake bundle for the round-robin constant arbiter:
// per-requester control tokens in, one constant token stream out.
interface handshake_constant_rr_arbiter_if #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 2,
   parameter int COUNT_WIDTH = 16
);
   logic [NUM_REQ-1:0]     ins_valid;
   logic [NUM_REQ-1:0]     ins_ready;
   logic [DATA_WIDTH-1:0]  outs;
   logic [INDEX_WIDTH-1:0] index;
   logic                   outs_valid;
   logic                   outs_ready;
   logic [COUNT_WIDTH-1:0] count;

   modport master (
      input  ins_valid,
      input  outs_ready,
      output ins_ready,
      output outs,
      output index,
      output outs_valid,
      output count
   );

   modport slave (
      output ins_valid,
      output outs_ready,
      input  ins_ready,
      input  outs,
      input  index,
      input  outs_valid,
      input  count
   );
endinterface

// File: rtl/handshake_constant_rr_arbiter.sv
// Round-robin arbiter feeding a one-slot constant output register;
// each accepted control token yields CONST_VALUE plus the served index.
module handshake_constant_rr_arbiter #(
   parameter int          NUM_REQ     = 4,
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] CONST_VALUE = 32'hFFFFFFFF,
   parameter int          INDEX_WIDTH = 2,
   parameter int          COUNT_WIDTH = 16
) (
   input logic clk,
   input logic rst,
   handshake_constant_rr_arbiter_if.master bus
);
   logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
   logic [INDEX_WIDTH-1:0] idx_q, idx_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   full_q, full_d;

   logic [INDEX_WIDTH-1:0] grant;
   logic                   found;
   logic                   any_valid;
   logic                   slot_free;
   logic                   accept;
   logic                   fire;
   int unsigned            cand;

   // Cyclic search starting at ptr; first valid requester wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = 32'(ptr_q) + 32'(k);
         if (cand >= 32'(NUM_REQ)) cand = cand - 32'(NUM_REQ);
         if (!found && bus.ins_valid[cand]) begin
            found = 1'b1;
            grant = INDEX_WIDTH'(cand);
         end
      end
   end

   assign any_valid = |bus.ins_valid;
   assign slot_free = !full_q || bus.outs_ready;
   assign accept    = any_valid && slot_free && rst;
   assign fire      = full_q && bus.outs_ready;

   always_comb begin
      bus.ins_ready = '0;
      for (int i = 0; i < NUM_REQ; i++)
         bus.ins_ready[i] = accept && (grant == INDEX_WIDTH'(i));
   end

   always_comb begin
      ptr_d  = ptr_q;
      idx_d  = idx_q;
      full_d = full_q;
      cnt_d  = fire ? cnt_q + 1'b1 : cnt_q;
      if (accept) begin
         full_d = 1'b1;
         idx_d  = grant;
         ptr_d  = (32'(grant) == 32'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end else if (bus.outs_ready) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q  <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   end

   assign bus.outs       = DATA_WIDTH'(CONST_VALUE);
   assign bus.outs_valid = full_q;
   assign bus.index      = idx_q;
   assign bus.count      = cnt_q;
endmodule

// File: tb/tb_handshake_constant_rr_arbiter.sv
// Bench for the round-robin constant arbiter: scoreboarded 4-way
// instance plus a 3-way instance with a 2-bit wrapping counter.
module tb_handshake_constant_rr_arbiter;
   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   handshake_constant_rr_arbiter_if #(
      .NUM_REQ(4), .DATA_WIDTH(32), .INDEX_WIDTH(2), .COUNT_WIDTH(16)
   ) ba ();
   handshake_constant_rr_arbiter_if #(
      .NUM_REQ(3), .DATA_WIDTH(32), .INDEX_WIDTH(2), .COUNT_WIDTH(2)
   ) bb ();

   handshake_constant_rr_arbiter #(
      .NUM_REQ(4), .DATA_WIDTH(32), .CONST_VALUE(32'hFFFFFFFF),
      .INDEX_WIDTH(2), .COUNT_WIDTH(16)
   ) dut_a (
      .clk(clk), .rst(rst_a), .bus(ba)
   );

   handshake_constant_rr_arbiter #(
      .NUM_REQ(3), .DATA_WIDTH(32), .CONST_VALUE(32'hFFFFFFFF),
      .INDEX_WIDTH(2), .COUNT_WIDTH(2)
   ) dut_b (
      .clk(clk), .rst(rst_b), .bus(bb)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model and scoreboard for the 4-way instance.
   int mptr = 0;
   bit mfull = 1'b0;
   int mcnt = 0;
   int q[$];
   int seen[$];

   always @(negedge clk) begin : mon_a
      int g;
      int e;
      int j;
      bit any;
      bit acc;
      logic [3:0] er;
      if (!rst_a) begin
         chk("rst_ready", 64'(ba.ins_ready), 64'(0));
         chk("rst_valid", 64'(ba.outs_valid), 64'(0));
         chk("rst_count", 64'(ba.count), 64'(0));
         chk("rst_index", 64'(ba.index), 64'(0));
         mptr = 0;
         mfull = 1'b0;
         mcnt = 0;
         q.delete();
      end else begin
         any = 1'b0;
         g = 0;
         for (int k = 0; k < 4; k++) begin
            j = (mptr + k) % 4;
            if (!any && ba.ins_valid[j]) begin
               any = 1'b1;
               g = j;
            end
         end
         acc = any && (!mfull || ba.outs_ready);
         er = acc ? 4'(1 << g) : 4'b0000;
         chk("ins_ready", 64'(ba.ins_ready), 64'(er));
         chk("outs_valid", 64'(ba.outs_valid), 64'(mfull));
         chk("count", 64'(ba.count), 64'(mcnt));
         if (mfull && ba.outs_ready) begin
            chk("sb_size", 64'(q.size()), 64'(1));
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("index", 64'(ba.index), 64'(e));
               chk("outs", 64'(ba.outs), 64'(32'hFFFFFFFF));
               seen.push_back(int'(ba.index));
            end
            mcnt = (mcnt + 1) & 16'hFFFF;
            mfull = 1'b0;
         end
         if (acc) begin
            q.push_back(g);
            mfull = 1'b1;
            mptr = (g + 1) % 4;
         end
      end
   end

   int fair_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int skip_exp[3] = '{1, 0, 1};
   int b_idx[5] = '{0, 1, 2, 0, 1};
   int b_cnt[5] = '{0, 1, 2, 3, 0};

   initial begin
      ba.ins_valid = 4'b1111;
      ba.outs_ready = 1'b1;
      bb.ins_valid = 3'b000;
      bb.outs_ready = 1'b1;

      // Held in reset with traffic present.
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         ba.ins_valid = 4'($urandom_range(1, 15));
         chk("rst_ready_d", 64'(ba.ins_ready), 64'(0));
      end

      // Fairness: all requesters valid, sink always ready.
      rst_a = 1'b1;
      ba.ins_valid = 4'b1111;
      seen.delete();
      cyc(8);
      ba.ins_valid = 4'b0000;
      cyc(1);
      chk("fair_count", 64'(ba.count), 64'(8));
      chk("fair_n", 64'(seen.size()), 64'(8));
      for (int i = 0; i < 8 && i < seen.size(); i++)
         chk("fair_idx", 64'(seen[i]), 64'(fair_exp[i]));

      // Skip and wrap: steer ptr to 2, then only 0 and 1 request.
      seen.delete();
      ba.ins_valid = 4'b0010;
      cyc(1);
      ba.ins_valid = 4'b0011;
      cyc(2);
      ba.ins_valid = 4'b0000;
      cyc(2);
      chk("skip_n", 64'(seen.size()), 64'(3));
      for (int i = 0; i < 3 && i < seen.size(); i++)
         chk("skip_idx", 64'(seen[i]), 64'(skip_exp[i]));
      chk("skip_count", 64'(ba.count), 64'(11));

      // Backpressure on a single requester.
      ba.outs_ready = 1'b0;
      ba.ins_valid = 4'b0100;
      cyc(1);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 64'(ba.outs_valid), 64'(1));
         chk("bp_index", 64'(ba.index), 64'(2));
         chk("bp_ready", 64'(ba.ins_ready), 64'(0));
         chk("bp_count", 64'(ba.count), 64'(11));
         cyc(1);
      end
      ba.outs_ready = 1'b1;
      @(negedge clk);
      chk("bp_reacc", 64'(ba.ins_ready), 64'(4'b0100));
      cyc(1);
      chk("bp_valid2", 64'(ba.outs_valid), 64'(1));
      chk("bp_index2", 64'(ba.index), 64'(2));
      chk("bp_count2", 64'(ba.count), 64'(12));
      ba.ins_valid = 4'b0000;
      cyc(2);
      chk("bp_count3", 64'(ba.count), 64'(13));
      chk("bp_empty", 64'(ba.outs_valid), 64'(0));

      // Reset mid-operation with a held token.
      rst_a = 1'b0;
      cyc(1);
      rst_a = 1'b1;
      ba.ins_valid = 4'b1111;
      cyc(5);
      ba.ins_valid = 4'b1000;
      cyc(1);
      ba.ins_valid = 4'b0000;
      ba.outs_ready = 1'b0;
      cyc(1);
      chk("mid_valid", 64'(ba.outs_valid), 64'(1));
      chk("mid_index", 64'(ba.index), 64'(3));
      chk("mid_count", 64'(ba.count), 64'(5));
      ba.outs_ready = 1'b1;
      rst_a = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(ba.outs_valid), 64'(0));
      chk("mid_rst_count", 64'(ba.count), 64'(0));
      chk("mid_rst_index", 64'(ba.index), 64'(0));
      cyc(1);
      rst_a = 1'b1;
      cyc(2);
      chk("post_rst_count", 64'(ba.count), 64'(0));

      // Three requesters, 2-bit counter wrapping.
      rst_b = 1'b1;
      bb.ins_valid = 3'b111;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("b_valid", 64'(bb.outs_valid), 64'(1));
         chk("b_index", 64'(bb.index), 64'(b_idx[i]));
         chk("b_count", 64'(bb.count), 64'(b_cnt[i]));
         chk("b_outs", 64'(bb.outs), 64'(32'hFFFFFFFF));
      end
      bb.ins_valid = 3'b000;
      cyc(2);
      chk("b_drain", 64'(bb.outs_valid), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
